gpio_in_sync: RTL and testbench

// - Conditions raw GPIO pins before they reach the GPIO CSR INPUT_STATUS field.
// - Per-bit path: metastability synchroniser -> programmable debounce filter -> rise/fall edge detect.
// - Enabled edges set sticky interrupt-pending bits; software clears them write-1-to-clear.
// - Sits between the pads and gpio_ctrl_top. Its gpio_sync output replaces the raw gpio_in feed.

---
 rtl/gpio_ctrl_pkg.sv | 9 +
 rtl/gpio_in_sync_if.sv | 30 +++
 rtl/gpio_in_sync_bit.sv | 68 ++++++
 rtl/gpio_in_sync.sv | 38 +++
 tb/tb_gpio_in_sync.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared GPIO types and sizes used by the input conditioning path and the CSR block.
package gpio_ctrl_pkg;

   localparam int GPIO_WIDTH      = 32;
   localparam int GPIO_DEBOUNCE_W = 8;

   typedef logic [GPIO_WIDTH-1:0] gpio_vec_t;

endpackage

// File: rtl/gpio_in_sync_if.sv
// Pad/CSR-facing signal bundle for gpio_in_sync; master drives pins and controls, slave is the block.
interface gpio_in_sync_if
   import gpio_ctrl_pkg::*;
#(
   parameter int WIDTH      = GPIO_WIDTH,
   parameter int DEBOUNCE_W = GPIO_DEBOUNCE_W
) ();

   logic [WIDTH-1:0]      gpio_in;
   logic [DEBOUNCE_W-1:0] debounce_thr;
   logic [WIDTH-1:0]      rise_en;
   logic [WIDTH-1:0]      fall_en;
   logic [WIDTH-1:0]      irq_clr;
   logic [WIDTH-1:0]      gpio_sync;
   logic [WIDTH-1:0]      rise_pulse;
   logic [WIDTH-1:0]      fall_pulse;
   logic [WIDTH-1:0]      irq_pending;
   logic                  irq;

   modport master (
      output gpio_in, debounce_thr, rise_en, fall_en, irq_clr,
      input  gpio_sync, rise_pulse, fall_pulse, irq_pending, irq
   );

   modport slave (
      input  gpio_in, debounce_thr, rise_en, fall_en, irq_clr,
      output gpio_sync, rise_pulse, fall_pulse, irq_pending, irq
   );

endinterface

// File: rtl/gpio_in_sync_bit.sv
// One GPIO bit: synchroniser, debounce filter, filtered level, edge pulses and sticky pending flag.
module gpio_in_sync_bit
   import gpio_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE_W  = GPIO_DEBOUNCE_W
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  pin,
   input  logic [DEBOUNCE_W-1:0] thr,
   input  logic                  rise_en,
   input  logic                  fall_en,
   input  logic                  irq_clr,
   output logic                  level,
   output logic                  rise_pulse,
   output logic                  fall_pulse,
   output logic                  pending
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_p0;
   logic [DEBOUNCE_W-1:0] cnt_p1;
   logic                  level_d_p2;
   logic                  s;
   logic                  set;

   assign s   = sync_p0[SYNC_STAGES-1];
   assign set = (rise_pulse & rise_en) | (fall_pulse & fall_en);

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         sync_p0    <= '0;
         cnt_p1     <= '0;
         level      <= 1'b0;
         level_d_p2 <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         pending    <= 1'b0;
      end else begin
         // synchroniser stage
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};

         // debounce stage: threshold compared live so a lowered value takes effect at once
         if (s != level) begin
            if (cnt_p1 >= thr) begin
               level  <= s;
               cnt_p1 <= '0;
            end else begin
               cnt_p1 <= cnt_p1 + DEBOUNCE_W'(1);
            end
         end else begin
            cnt_p1 <= '0;
         end

         // edge stage: pulses trail the level change by one cycle
         level_d_p2 <= level;
         rise_pulse <= level & ~level_d_p2;
         fall_pulse <= ~level & level_d_p2;

         // pending stage: a qualifying edge beats a simultaneous clear
         if (set)
            pending <= 1'b1;
         else if (irq_clr)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/gpio_in_sync.sv
// GPIO input conditioning: one gpio_in_sync_bit per pin, pending bits OR-ed into a single irq.
module gpio_in_sync
   import gpio_ctrl_pkg::*;
#(
   parameter int WIDTH       = GPIO_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE_W  = GPIO_DEBOUNCE_W
) (
   input  logic           sys_clk,
   input  logic           rst_n,
   gpio_in_sync_if.slave  bus
);

   logic [WIDTH-1:0] pending_vec;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_in_sync_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE_W  (DEBOUNCE_W)
      ) u_bit (
         .sys_clk    (sys_clk),
         .rst_n      (rst_n),
         .pin        (bus.gpio_in[i]),
         .thr        (bus.debounce_thr),
         .rise_en    (bus.rise_en[i]),
         .fall_en    (bus.fall_en[i]),
         .irq_clr    (bus.irq_clr[i]),
         .level      (bus.gpio_sync[i]),
         .rise_pulse (bus.rise_pulse[i]),
         .fall_pulse (bus.fall_pulse[i]),
         .pending    (pending_vec[i])
      );
   end

   assign bus.irq_pending = pending_vec;
   assign bus.irq         = |pending_vec;

endmodule

// File: tb/tb_gpio_in_sync.sv
// Directed bench for gpio_in_sync: latency, glitch rejection, pending set/clear, reset and live threshold.
module tb_gpio_in_sync;
   import gpio_ctrl_pkg::*;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   gpio_in_sync_if #(.WIDTH(GPIO_WIDTH), .DEBOUNCE_W(GPIO_DEBOUNCE_W)) bus ();

   gpio_in_sync #(
      .WIDTH       (GPIO_WIDTH),
      .SYNC_STAGES (2),
      .DEBOUNCE_W  (GPIO_DEBOUNCE_W)
   ) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      bus.gpio_in      = '0;
      bus.debounce_thr = '0;
      bus.rise_en      = '0;
      bus.fall_en      = '0;
      bus.irq_clr      = '0;
      step(2);
      check("rst_gpio_sync",   bus.gpio_sync,   32'h0);
      check("rst_rise_pulse",  bus.rise_pulse,  32'h0);
      check("rst_fall_pulse",  bus.fall_pulse,  32'h0);
      check("rst_irq_pending", bus.irq_pending, 32'h0);
      check("rst_irq",         {31'h0, bus.irq}, 32'h0);
      rst_n = 1'b1;
      step(2);

      // 1) thr=0: three-cycle latency, rise then fall pulses
      bus.gpio_in[0] = 1'b1;
      step(2);
      check("t1_sync_early", {31'h0, bus.gpio_sync[0]}, 32'h0);
      step(1);
      check("t1_sync_at3",   {31'h0, bus.gpio_sync[0]}, 32'h1);
      check("t1_rise_at3",   {31'h0, bus.rise_pulse[0]}, 32'h0);
      step(1);
      check("t1_rise_at4",   {31'h0, bus.rise_pulse[0]}, 32'h1);
      step(1);
      check("t1_rise_at5",   {31'h0, bus.rise_pulse[0]}, 32'h0);
      check("t1_no_pending", bus.irq_pending, 32'h0);
      bus.gpio_in[0] = 1'b0;
      step(4);
      check("t1_fall_at4",   {31'h0, bus.fall_pulse[0]}, 32'h1);
      step(1);
      check("t1_fall_at5",   {31'h0, bus.fall_pulse[0]}, 32'h0);

      // 2) thr=4: 3-cycle glitch rejected, sustained high accepted at cycle 7
      bus.debounce_thr = 8'd4;
      bus.gpio_in[5] = 1'b1;
      step(3);
      bus.gpio_in[5] = 1'b0;
      step(8);
      check("t2_glitch_rej", {31'h0, bus.gpio_sync[5]}, 32'h0);
      bus.gpio_in[5] = 1'b1;
      step(6);
      check("t2_sync_at6",   {31'h0, bus.gpio_sync[5]}, 32'h0);
      step(1);
      check("t2_sync_at7",   {31'h0, bus.gpio_sync[5]}, 32'h1);
      step(1);
      check("t2_rise",       {31'h0, bus.rise_pulse[5]}, 32'h1);
      check("t2_no_fall",    {31'h0, bus.fall_pulse[5]}, 32'h0);

      // 3) rise-only enable on bit3, then W1C
      bus.debounce_thr = 8'd0;
      bus.rise_en[3] = 1'b1;
      bus.gpio_in[3] = 1'b1;
      step(4);
      check("t3_pulse",      {31'h0, bus.rise_pulse[3]}, 32'h1);
      check("t3_pend_early", bus.irq_pending, 32'h0);
      step(1);
      check("t3_pend_set",   bus.irq_pending, 32'h0000_0008);
      check("t3_irq_set",    {31'h0, bus.irq}, 32'h1);
      step(15);
      bus.gpio_in[3] = 1'b0;
      step(6);
      check("t3_sync_low",   {31'h0, bus.gpio_sync[3]}, 32'h0);
      check("t3_pend_fall",  bus.irq_pending, 32'h0000_0008);
      bus.irq_clr[3] = 1'b1;
      step(1);
      bus.irq_clr[3] = 1'b0;
      check("t3_pend_clr",   bus.irq_pending, 32'h0);
      check("t3_irq_clr",    {31'h0, bus.irq}, 32'h0);

      // 4) clear coincident with a qualifying pulse: set wins
      bus.gpio_in[3] = 1'b1;
      step(4);
      check("t4_pulse",      {31'h0, bus.rise_pulse[3]}, 32'h1);
      bus.irq_clr[3] = 1'b1;
      step(1);
      bus.irq_clr[3] = 1'b0;
      check("t4_set_wins",   bus.irq_pending, 32'h0000_0008);
      bus.irq_clr[3] = 1'b1;
      step(1);
      bus.irq_clr[3] = 1'b0;
      check("t4_clr_after",  bus.irq_pending, 32'h0);

      // 5) reset mid-count on bit7 discards progress
      bus.debounce_thr = 8'd200;
      bus.gpio_in[7] = 1'b1;
      step(102);
      check("t5_mid_count",  {31'h0, bus.gpio_sync[7]}, 32'h0);
      rst_n = 1'b0;
      step(1);
      check("t5_rst_sync",   bus.gpio_sync,   32'h0);
      check("t5_rst_rise",   bus.rise_pulse,  32'h0);
      check("t5_rst_fall",   bus.fall_pulse,  32'h0);
      check("t5_rst_pend",   bus.irq_pending, 32'h0);
      check("t5_rst_irq",    {31'h0, bus.irq}, 32'h0);
      rst_n = 1'b1;
      step(202);
      check("t5_sync_202",   {31'h0, bus.gpio_sync[7]}, 32'h0);
      step(1);
      check("t5_sync_203",   {31'h0, bus.gpio_sync[7]}, 32'h1);

      // 6) lowering the threshold below the running count releases the update next edge
      bus.gpio_in[9] = 1'b1;
      step(52);
      check("t6_before_low", {31'h0, bus.gpio_sync[9]}, 32'h0);
      bus.debounce_thr = 8'd10;
      step(1);
      check("t6_next_edge",  {31'h0, bus.gpio_sync[9]}, 32'h1);
      bus.gpio_in[9] = 1'b0;
      step(12);
      check("t6_fresh_12",   {31'h0, bus.gpio_sync[9]}, 32'h1);
      step(1);
      check("t6_fresh_13",   {31'h0, bus.gpio_sync[9]}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
